// File: rtl/axis_fifo_param.sv
// AXI-Stream FIFO with registered first-word-fall-through output, TLAST carriage,
// data count, programmable full/empty flags and optional whole-packet release.
module axis_fifo_param #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned DEPTH             = 512,
    parameter int unsigned PROG_FULL_THRESH  = 480,
    parameter int unsigned PROG_FULL_HYST    = 10,
    parameter int unsigned PROG_EMPTY_THRESH = 4,
    parameter int unsigned PACKET_MODE       = 0
) (
    input  logic                      s_aclk,
    input  logic                      s_areset,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic [$clog2(DEPTH):0]    data_count,
    output logic                      prog_full,
    output logic                      prog_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] PF_SET = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PF_CLR = CW'(PROG_FULL_THRESH - PROG_FULL_HYST);
    localparam logic [CW-1:0] PE_C   = CW'(PROG_EMPTY_THRESH);

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d, pkt_count_q, pkt_count_d;
    logic [CW-1:0]         mem_count;
    logic                  forced_q, forced_d, force_now;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  tready_q, tready_d;
    logic                  prog_full_q, prog_full_d;
    logic                  prog_empty_q, prog_empty_d;
    logic                  wr, rd, load, release_ok;
    logic [DATA_WIDTH:0]   head;

    assign s_axis_tready = ~s_areset & tready_q;
    assign wr            = s_axis_tvalid & s_axis_tready;
    assign rd            = out_valid_q & m_axis_tready;
    assign head          = mem[rd_ptr_q];
    // Words still in the array, i.e. excluding the one held in the output register.
    assign mem_count     = count_q - CW'(out_valid_q);

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign data_count    = count_q;
    assign prog_full     = prog_full_q;
    assign prog_empty    = prog_empty_q;

    always_comb begin
        force_now  = 1'b0;
        release_ok = (mem_count != '0);
        if (PACKET_MODE != 0) begin
            // A full FIFO with no complete packet would deadlock; let it drain.
            force_now  = (count_q == FULL_C) && (pkt_count_q == '0);
            release_ok = (mem_count != '0) &&
                         ((pkt_count_q != '0) || forced_q || force_now);
        end
        load = (~out_valid_q | rd) & release_ok;

        forced_d = forced_q;
        if (rd && out_last_q)
            forced_d = 1'b0;
        else if (force_now)
            forced_d = 1'b1;

        pkt_count_d = pkt_count_q + CW'(wr & s_axis_tlast) - CW'(load & head[DATA_WIDTH]);
        count_d     = count_q + CW'(wr) - CW'(rd);
        wr_ptr_d    = wr_ptr_q + AW'(wr);
        rd_ptr_d    = rd_ptr_q + AW'(load);

        tready_d     = (count_d < FULL_C);
        prog_empty_d = (count_d <= PE_C);
        prog_full_d  = prog_full_q;
        if (count_d >= PF_SET)
            prog_full_d = 1'b1;
        else if (count_d < PF_CLR)
            prog_full_d = 1'b0;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head[DATA_WIDTH-1:0];
            out_last_d  = head[DATA_WIDTH];
        end else if (rd) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s_aclk) begin
        if (wr)
            mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_count_q  <= '0;
            forced_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            tready_q     <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_count_q  <= pkt_count_d;
            forced_q     <= forced_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            tready_q     <= tready_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
        end
    end

endmodule

// File: tb/tb_axis_fifo_param.sv
// Directed bench for axis_fifo_param: a streaming instance and a packet-mode instance,
// both DEPTH=16, THRESH=12, HYST=4, EMPTY_THRESH=4.
module tb_axis_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s0_valid, s0_ready, s0_last, m0_valid, m0_ready, m0_last, pf0, pe0;
    logic [7:0] s0_data, m0_data;
    logic [4:0] cnt0;
    logic       s1_valid, s1_ready, s1_last, m1_valid, m1_ready, m1_last, pf1, pe1;
    logic [7:0] s1_data, m1_data;
    logic [4:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int sent, recv;
    logic wr_now, rd_now;

    axis_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(16), .PROG_FULL_THRESH(12), .PROG_FULL_HYST(4),
        .PROG_EMPTY_THRESH(4), .PACKET_MODE(0)
    ) u_dut (
        .s_aclk(clk), .s_areset(rst),
        .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready),
        .s_axis_tdata(s0_data), .s_axis_tlast(s0_last),
        .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready),
        .m_axis_tdata(m0_data), .m_axis_tlast(m0_last),
        .data_count(cnt0), .prog_full(pf0), .prog_empty(pe0)
    );

    axis_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(16), .PROG_FULL_THRESH(12), .PROG_FULL_HYST(4),
        .PROG_EMPTY_THRESH(4), .PACKET_MODE(1)
    ) u_dut_pkt (
        .s_aclk(clk), .s_areset(rst),
        .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
        .s_axis_tdata(s1_data), .s_axis_tlast(s1_last),
        .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
        .m_axis_tdata(m1_data), .m_axis_tlast(m1_last),
        .data_count(cnt1), .prog_full(pf1), .prog_empty(pe1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        s0_valid = 0; s0_data = '0; s0_last = 0; m0_ready = 0;
        s1_valid = 0; s1_data = '0; s1_last = 0; m1_ready = 0;
        repeat (2) @(negedge clk);

        check("rst_tready",  64'(s0_ready), 64'(0));
        check("rst_tvalid",  64'(m0_valid), 64'(0));
        check("rst_tdata",   64'(m0_data),  64'(0));
        check("rst_tlast",   64'(m0_last),  64'(0));
        check("rst_count",   64'(cnt0),     64'(0));
        check("rst_pfull",   64'(pf0),      64'(0));
        check("rst_pempty",  64'(pe0),      64'(1));
        check("rst_pkt_cnt", 64'(cnt1),     64'(0));
        rst = 0;
        @(negedge clk);
        check("post_rst_tready",     64'(s0_ready), 64'(1));
        check("post_rst_tready_pkt", 64'(s1_ready), 64'(1));

        // single word latency
        s0_valid = 1; s0_data = 8'h5A;
        @(negedge clk);
        s0_valid = 0;
        check("lat_n_tvalid", 64'(m0_valid), 64'(0));
        check("lat_n_count",  64'(cnt0),     64'(1));
        @(negedge clk);
        check("lat_n1_tvalid", 64'(m0_valid), 64'(1));
        check("lat_n1_tdata",  64'(m0_data),  64'(8'h5A));
        m0_ready = 1;
        @(negedge clk);
        m0_ready = 0;
        check("empty_tvalid", 64'(m0_valid), 64'(0));
        check("empty_count",  64'(cnt0),     64'(0));

        // fill to full with output stalled
        for (int i = 0; i < 16; i++) begin
            check("fill_count",  64'(cnt0),     64'(i));
            check("fill_tready", 64'(s0_ready), 64'(1));
            check("fill_pfull",  64'(pf0),      64'(i >= 12));
            check("fill_pempty", 64'(pe0),      64'(i <= 4));
            s0_valid = 1; s0_data = 8'(i);
            @(negedge clk);
        end
        s0_valid = 0;
        check("full_tready", 64'(s0_ready), 64'(0));
        check("full_count",  64'(cnt0),     64'(16));
        check("full_pfull",  64'(pf0),      64'(1));
        check("full_pempty", 64'(pe0),      64'(0));

        // drain: prog_full holds down to 8, clears at 7
        for (int j = 0; j < 16; j++) begin
            check("drain_tvalid", 64'(m0_valid), 64'(1));
            check("drain_tdata",  64'(m0_data),  64'(j));
            check("drain_count",  64'(cnt0),     64'(16 - j));
            check("drain_tready", 64'(s0_ready), 64'(j > 0));
            check("drain_pfull",  64'(pf0),      64'((16 - j) >= 8));
            check("drain_pempty", 64'(pe0),      64'((16 - j) <= 4));
            m0_ready = 1;
            @(negedge clk);
        end
        m0_ready = 0;
        check("drained_tvalid", 64'(m0_valid), 64'(0));
        check("drained_count",  64'(cnt0),     64'(0));
        check("drained_pfull",  64'(pf0),      64'(0));
        check("drained_pempty", 64'(pe0),      64'(1));

        // simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) begin
            s0_valid = 1; s0_data = 8'(100 + i);
            @(negedge clk);
        end
        s0_valid = 0;
        check("pre_sim_count", 64'(cnt0),    64'(5));
        check("pre_sim_tdata", 64'(m0_data), 64'(100));
        for (int k = 0; k < 20; k++) begin
            check("sim_tvalid", 64'(m0_valid), 64'(1));
            check("sim_tdata",  64'(m0_data),  64'(100 + k));
            check("sim_count",  64'(cnt0),     64'(5));
            s0_valid = 1; s0_data = 8'(105 + k); m0_ready = 1;
            @(negedge clk);
        end
        s0_valid = 0; m0_ready = 0;
        check("post_sim_tdata", 64'(m0_data), 64'(120));
        check("post_sim_count", 64'(cnt0),    64'(5));

        // packet mode: 4-word packet held until tlast accepted
        for (int i = 0; i < 4; i++) begin
            s1_valid = 1; s1_data = 8'(8'hA0 + i); s1_last = (i == 3);
            @(negedge clk);
            check("pkt_hold_tvalid", 64'(m1_valid), 64'(0));
        end
        s1_valid = 0; s1_last = 0;
        @(negedge clk);
        check("pkt_rel_tvalid", 64'(m1_valid), 64'(1));
        check("pkt_rel_tdata",  64'(m1_data),  64'(8'hA0));
        m1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("pkt_out_tvalid", 64'(m1_valid), 64'(1));
            check("pkt_out_tdata",  64'(m1_data),  64'(8'hA0 + i));
            check("pkt_out_tlast",  64'(m1_last),  64'(i == 3));
            @(negedge clk);
        end
        m1_ready = 0;
        check("pkt_done_tvalid", 64'(m1_valid), 64'(0));
        check("pkt_done_count",  64'(cnt1),     64'(0));

        // forced release of a 20-word packet
        for (int i = 0; i < 16; i++) begin
            s1_valid = 1; s1_data = 8'(8'hB0 + i); s1_last = 0;
            @(negedge clk);
        end
        s1_valid = 0;
        check("forced_full_count",  64'(cnt1),     64'(16));
        check("forced_full_tready", 64'(s1_ready), 64'(0));
        check("forced_full_tvalid", 64'(m1_valid), 64'(0));
        @(negedge clk);
        check("forced_start_tvalid", 64'(m1_valid), 64'(1));
        check("forced_start_tdata",  64'(m1_data),  64'(8'hB0));
        sent = 16; recv = 0;
        m1_ready = 1;
        for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
            s1_valid = (sent < 20);
            s1_data  = 8'(8'hB0 + sent);
            s1_last  = (sent == 19);
            wr_now = s1_valid && s1_ready;
            rd_now = m1_valid && m1_ready;
            if (rd_now) begin
                check("forced_tdata", 64'(m1_data), 64'(8'hB0 + recv));
                check("forced_tlast", 64'(m1_last), 64'(recv == 19));
                recv++;
            end
            if (wr_now) sent++;
            @(negedge clk);
        end
        s1_valid = 0; s1_last = 0; m1_ready = 0;
        check("forced_recv",       64'(recv),     64'(20));
        check("forced_end_tvalid", 64'(m1_valid), 64'(0));
        check("forced_end_count",  64'(cnt1),     64'(0));

        // leave a complete packet pending, then reset mid-stream
        s1_valid = 1; s1_data = 8'hC0; s1_last = 0;
        @(negedge clk);
        s1_data = 8'hC1; s1_last = 1;
        @(negedge clk);
        s1_valid = 0; s1_last = 0;
        @(negedge clk);
        check("pre_rst_pkt_tvalid", 64'(m1_valid), 64'(1));
        s0_valid = 1; s0_data = 8'h77; m0_ready = 1;
        rst = 1;
        @(negedge clk);
        check("mid_rst_tready", 64'(s0_ready), 64'(0));
        check("mid_rst_tvalid", 64'(m0_valid), 64'(0));
        check("mid_rst_tdata",  64'(m0_data),  64'(0));
        check("mid_rst_tlast",  64'(m0_last),  64'(0));
        check("mid_rst_count",  64'(cnt0),     64'(0));
        check("mid_rst_pfull",  64'(pf0),      64'(0));
        check("mid_rst_pempty", 64'(pe0),      64'(1));
        check("mid_rst_pkt_tvalid", 64'(m1_valid), 64'(0));
        check("mid_rst_pkt_count",  64'(cnt1),     64'(0));
        rst = 0; s0_valid = 0; m0_ready = 0;
        s1_valid = 1; s1_data = 8'hD0; s1_last = 0;
        @(negedge clk);
        s1_valid = 0;
        check("post_rst_tready_again", 64'(s0_ready), 64'(1));
        repeat (2) @(negedge clk);
        check("post_rst_pkt_hold",  64'(m1_valid), 64'(0));
        check("post_rst_pkt_count", 64'(cnt1),     64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_fifo_param.md
# axis_fifo_param

Parametrised AXI-Stream FIFO with a registered first-word-fall-through output, TLAST carriage, data count, programmable full/empty flags with hysteresis, and an optional packet mode that holds output until a complete packet is buffered. It replaces the fixed 8-bit/512-deep output buffer at the back end of the Sobel pipeline. It is also used between the filter and the DMA/VDMA interface, where frame-line packets must leave the FIFO contiguously.

## Interface
- DATA_WIDTH, 8: TDATA width in bits (1..64).
- DEPTH, 512: total capacity in words, power of two, 4..4096. Includes the output register.
- PROG_FULL_THRESH, 480: prog_full asserts when count >= this value.
- PROG_FULL_HYST, 10: prog_full deasserts when count < PROG_FULL_THRESH - PROG_FULL_HYST.
- PROG_EMPTY_THRESH, 4: prog_empty asserts when count <= this value.
- PACKET_MODE, 0: 1 means output is released only on complete packets.

Ports:
- s_aclk, in, 1: sole clock, rising edge.
- s_areset, in, 1: synchronous, active-high reset.
- s_axis_tvalid, in, 1: input word valid.
- s_axis_tready, out, 1: FIFO can accept a word.
- s_axis_tdata, in, DATA_WIDTH: input data.
- s_axis_tlast, in, 1: last word of packet.
- m_axis_tvalid, out, 1: output word valid.
- m_axis_tready, in, 1: downstream accepts.
- m_axis_tdata, out, DATA_WIDTH: output data, registered.
- m_axis_tlast, out, 1: output TLAST, registered.
- data_count, out, clog2(DEPTH)+1: words accepted but not yet delivered, range 0..DEPTH.
- prog_full, out, 1: programmable full, with hysteresis.
- prog_empty, out, 1: programmable empty.

## Operation
- Write: wr = s_axis_tvalid & s_axis_tready. The {tlast, tdata} pair is stored at wr_ptr, and wr_ptr increments modulo DEPTH. Pointers are clog2(DEPTH) bits and wrap naturally.
- s_axis_tready = ~s_areset & (data_count < DEPTH). The flag is registered and is derived from the next-count value, with no combinational path from m_axis_tready.
- Read: rd = m_axis_tvalid & m_axis_tready.
- The output register loads the word at rd_ptr when it is empty or being drained (rd), and a release condition holds. rd_ptr advances on each load.
- Release condition:
  - PACKET_MODE=0: the memory holds at least 1 word.
  - PACKET_MODE=1: pkt_count > 0, or the forced flag is set.
- pkt_count:
  - Increments on each wr with tlast=1.
  - Decrements on each load of a tlast=1 word into the output register.
  - A simultaneous increment and decrement leaves it unchanged.
- Forced release (PACKET_MODE=1 only):
  - Sets when data_count == DEPTH and pkt_count == 0, so that an oversize packet cannot deadlock.
  - Clears when a tlast=1 word is delivered (rd with m_axis_tlast=1).
- data_count: +1 on wr only, −1 on rd only, unchanged when both occur or neither occurs.
- prog_full:
  - Set when next_count >= PROG_FULL_THRESH.
  - Cleared when next_count < PROG_FULL_THRESH - PROG_FULL_HYST.
  - Otherwise holds.
- prog_empty = (next_count <= PROG_EMPTY_THRESH), registered.
- m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Reset mid-operation discards all contents, pkt_count, and the forced flag. Memory contents are not cleared, since they are unobservable.

## Timing
- Reset values, one edge after s_areset=1:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - data_count=0, prog_full=0, prog_empty=1.
  - s_axis_tready=0 while s_areset=1; it is 1 from the first edge with reset low.
- Latency, PACKET_MODE=0: a word written into an empty FIFO at edge N has m_axis_tvalid=1 after edge N+1.
- Latency, PACKET_MODE=1: the packet's first word is valid after the edge following acceptance of its tlast word, or following forced release.
- Throughput: 1 word/cycle sustained in both directions when not full or empty. Back-to-back packets cause no bubble.
- Full boundary:
  - At data_count == DEPTH, s_axis_tready=0.
  - A rd at that edge makes tready 1 after that edge.
  - wr and rd together at full cannot occur, because tready=0.
- Empty boundary: the last word delivered with nothing pending makes m_axis_tvalid=0 after that edge. A wr on the same edge makes the new word valid one edge later.
- Flags and data_count update on the same edge as the pointer and count change.

## Test plan
- Reset with DATA_WIDTH=8, DEPTH=16: after reset, tready=1, tvalid=0, data_count=0, prog_empty=1. Write 0x5A at edge N; tvalid=1 with tdata=0x5A after edge N+1.
- Fill, DEPTH=16, m_axis_tready=0: write 16 words 0..15. Tready falls after the 16th write, data_count=16, prog_full=1 (THRESH=12). Drain: outputs 0..15 in order, tready=1 after the first rd.
- Hysteresis, THRESH=12, HYST=4: count 12 gives prog_full=1; count 9 keeps it 1; count 7 gives 0.
- Simultaneous: at data_count=5, wr and rd on 20 consecutive edges. Count stays 5, the data sequence is intact, and there are no bubbles.
- Packet mode: write a 4-word packet with tlast on word 3. Tvalid stays 0 until the edge after the tlast write. Output is 4 contiguous words with m_axis_tlast on the 4th.
- Forced release, DEPTH=16, PACKET_MODE=1: send a 20-word packet. At count 16 the output starts; all 20 words arrive in order with tlast on word 20. Assert reset mid-stream: all outputs return to their reset values one edge later.
